// File: rtl/buffer_drain_axis_pkg.sv
// Shared definitions for the buffer drain stage.
//   DW_DEFAULT / BURST_DEFAULT / DEPTH_DEFAULT : default data width, burst
//   length and FIFO depth.
//   KEEP_ALL    : all-ones byte-keep for the default data width.
//   level_width : bits needed to hold an occupancy of 0..depth inclusive.
package buffer_drain_axis_pkg;

  localparam int unsigned DW_DEFAULT    = 64;
  localparam int unsigned BURST_DEFAULT = 16;
  localparam int unsigned DEPTH_DEFAULT = 32;

  localparam logic [DW_DEFAULT/8-1:0] KEEP_ALL = '1;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/buffer_drain_axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head output.
//   clk, rst : clock and synchronous active-high reset
//   wr_en    : write request, ignored while full
//   wr_data  : write word
//   rd_en    : read request, ignored while empty
//   rd_data  : current head word (valid while !empty)
//   level    : occupancy 0..DEPTH
//   full     : level == DEPTH
//   empty    : level == 0
module sync_fifo
  import buffer_drain_axis_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_ptr_next;
  logic          do_wr;
  logic          do_rd;
  logic          drains_to_zero;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    rd_ptr_next    = rd_ptr + {{AW{1'b0}}, do_rd};
    // Nothing older than the incoming word remains after this edge.
    drains_to_zero = (level == {{AW{1'b0}}, do_rd});
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // The head register is reloaded every edge from the next read slot; when
  // the FIFO would otherwise run dry, the word being written bypasses memory
  // so a push and a pop at level 1 keep the output continuously valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_next;
      if (drains_to_zero) begin
        if (do_wr) begin
          rd_data <= wr_data;
        end
      end else begin
        rd_data <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/buffer_drain_axis.sv
// Drain stage: absorbs fixed-length bursts (no per-beat backpressure) into a
// FIFO and re-emits them as an AXI4-Stream master with tlast every BURST_g
// beats.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_valid_i/data : upstream word, dropped if the FIFO is full
//   space_o           : room for one complete burst
//   m_axis_*          : AXI4-Stream master (tkeep constant all-ones)
//   level_o           : FIFO occupancy
//   overflow_o        : sticky, a push arrived while full
//   bursts_out_o      : completed output bursts, wraps mod 2^16
module buffer_drain_axis
  import buffer_drain_axis_pkg::*;
#(
  parameter int unsigned DW_g    = DW_DEFAULT,
  parameter int unsigned BURST_g = BURST_DEFAULT,
  parameter int unsigned DEPTH_g = DEPTH_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_valid_i,
  input  logic [DW_g-1:0]            push_data_i,
  output logic                       space_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [DW_g-1:0]            m_axis_tdata_o,
  output logic [DW_g/8-1:0]          m_axis_tkeep_o,
  output logic                       m_axis_tlast_o,
  output logic [$clog2(DEPTH_g):0]   level_o,
  output logic                       overflow_o,
  output logic [15:0]                bursts_out_o
);

  localparam int unsigned BW = (BURST_g > 1) ? $clog2(BURST_g) : 1;
  localparam int unsigned LW = level_width(DEPTH_g);

  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          pop;
  logic          beat_last;
  logic [BW-1:0] beat;

  sync_fifo #(
    .DW    (DW_g),
    .DEPTH (DEPTH_g)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (push_valid_i),
    .wr_data (push_data_i),
    .rd_en   (m_axis_tready_i),
    .rd_data (m_axis_tdata_o),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign m_axis_tvalid_o = !empty;
  assign m_axis_tkeep_o  = '1;
  assign pop             = m_axis_tvalid_o && m_axis_tready_i;
  assign beat_last       = (beat == BW'(BURST_g - 1));
  assign m_axis_tlast_o  = m_axis_tvalid_o && beat_last;
  assign level_o         = level;
  assign space_o         = (level <= LW'(DEPTH_g - BURST_g));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat         <= '0;
      overflow_o   <= 1'b0;
      bursts_out_o <= '0;
    end else begin
      // Fullness is judged before any same-cycle pop frees a slot.
      if (push_valid_i && full) begin
        overflow_o <= 1'b1;
      end
      if (pop) begin
        if (beat_last) begin
          beat         <= '0;
          bursts_out_o <= bursts_out_o + 16'd1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_buffer_drain_axis.sv
module tb_buffer_drain_axis;

  localparam int unsigned DW    = 64;
  localparam int unsigned BURST = 16;
  localparam int unsigned DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic [DW-1:0]    push_data;
  logic             space;
  logic             tvalid;
  logic             tready;
  logic [DW-1:0]    tdata;
  logic [DW/8-1:0]  tkeep;
  logic             tlast;
  logic [5:0]       level;
  logic             overflow;
  logic [15:0]      bursts_out;

  always #5 clk = ~clk;

  buffer_drain_axis #(
    .DW_g    (DW),
    .BURST_g (BURST),
    .DEPTH_g (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .push_valid_i    (push_valid),
    .push_data_i     (push_data),
    .space_o         (space),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .m_axis_tdata_o  (tdata),
    .m_axis_tkeep_o  (tkeep),
    .m_axis_tlast_o  (tlast),
    .level_o         (level),
    .overflow_o      (overflow),
    .bursts_out_o    (bursts_out)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words are appended at wr_cnt (model side),
  // consumed at rd_cnt (monitor side); occupancy is their difference.
  logic [63:0] exp_mem [1024];
  int unsigned wr_cnt  = 0;
  int unsigned rd_cnt  = 0;
  bit          pend    = 0;
  bit          exp_ovf = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_ovf = 0;
    end else if (push_valid) begin
      if ((wr_cnt - rd_cnt) + (pend ? 1 : 0) < DEPTH) begin
        exp_mem[wr_cnt % 1024] = push_data;
        wr_cnt++;
      end else begin
        exp_ovf = 1;
      end
    end
  end

  // Monitor: compares outputs each cycle away from the edge and retires the
  // head of the model queue whenever a handshake will occur.
  initial begin
    int unsigned beat     = 0;
    logic [15:0] bursts   = 0;
    bit          last_rst = 1;
    int unsigned size;
    @(posedge clk);
    forever begin
      @(negedge clk);
      size = wr_cnt - rd_cnt;
      check("tvalid", 64'(tvalid), 64'(size != 0));
      check("level", 64'(level), 64'(size));
      check("space", 64'(space), 64'((DEPTH - size) >= BURST));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("bursts_out", 64'(bursts_out), 64'(bursts));
      check("tkeep", 64'(tkeep), 64'hFF);
      check("tlast", 64'(tlast), 64'((size != 0) && (beat == BURST - 1)));
      if (size != 0) begin
        check("tdata", tdata, exp_mem[rd_cnt % 1024]);
      end else if (last_rst) begin
        check("tdata_reset", tdata, 64'h0);
      end
      last_rst = rst;
      if (rst) begin
        rd_cnt = wr_cnt;
        beat   = 0;
        bursts = 0;
        pend   = 0;
      end else if (size != 0 && tready) begin
        pend = 1;
        rd_cnt++;
        if (beat == BURST - 1) begin
          beat = 0;
          bursts++;
        end else begin
          beat++;
        end
      end else begin
        pend = 0;
      end
    end
  end

  // Stimulus: 0 = tready low, 1 = tready high, 2 = tready random.
  int mode = 0;

  task automatic tick(input bit pv, input logic [63:0] pd);
    @(posedge clk);
    #1;
    push_valid = pv;
    push_data  = pd;
    case (mode)
      1:       tready = 1'b1;
      2:       tready = 1'($urandom % 2);
      default: tready = 1'b0;
    endcase
  endtask

  task automatic do_reset(input int unsigned n);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    push_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b0, 64'h0);
  endtask

  task automatic burst(input logic [63:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b1, base + 64'(i));
  endtask

  initial begin
    rst        = 1'b1;
    push_valid = 1'b0;
    push_data  = '0;
    tready     = 1'b0;
    do_reset(3);

    // One burst with the sink always ready.
    mode = 1;
    burst(64'h0, 16);
    idle(20);

    // Two bursts into a stalled sink, then one more push while full.
    mode = 0;
    burst(64'h100, 32);
    tick(1'b1, 64'h999);
    idle(3);
    mode = 1;
    idle(40);

    // Random backpressure during one burst.
    mode = 2;
    burst(64'hA000, 16);
    idle(60);

    // Reset in the middle of a burst, then a clean burst.
    mode = 1;
    burst(64'h200, 8);
    do_reset(1);
    burst(64'h300, 16);
    idle(20);

    // Push and pop together at level 1.
    mode = 0;
    tick(1'b1, 64'h400);
    mode = 1;
    tick(1'b1, 64'h401);
    idle(5);

    // Random traffic, including overflow under backpressure.
    mode = 2;
    for (int unsigned i = 0; i < 300; i++) begin
      tick(1'($urandom % 3 != 0), {$urandom, $urandom});
    end
    mode = 1;
    idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
